// File: rtl/gate_tt_pkg.sv
// Shared types and widths for the two-input gate truth-table sequencer.
package gate_tt_pkg;
  localparam int TT_W  = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_e;
endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times the settle window of each input vector.
module settle_timer
  import gate_tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt_q <= '0;
    else if (load)                 cnt_q <= load_val;
    else if (dec && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/gate_tt_sequencer.sv
// Walks {b,a} through 00..11, samples the gate output after a settle window
// and compares the captured truth table against a latched expected table.
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] expected,
  output logic            gate_a,
  output logic            gate_b,
  input  logic            gate_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TT_W-1:0] tt,
  output logic [IDX_W-1:0] fail_idx,
  output logic [2:0]      mism_cnt
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TT_W-1:0]  exp_q, exp_d;
  logic [TT_W-1:0]  tt_q, tt_d;
  logic             pass_q, pass_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [2:0]       mism_q, mism_d;

  logic             t_load, t_dec, t_zero;
  logic [TT_W-1:0]  tt_smp, diff;
  logic [IDX_W-1:0] fidx_c;
  logic [2:0]       mism_c;
  logic             vec_act;

  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (CNT_W'(SETTLE - 1)),
    .zero     (t_zero)
  );

  // Results are evaluated on the table as it will look after the current
  // sample, so they are registered in time for the FINISH cycle.
  always_comb begin
    tt_smp         = tt_q;
    tt_smp[idx_q]  = gate_y;
    diff           = tt_smp ^ exp_q;
    mism_c         = '0;
    fidx_c         = '0;
    for (int i = 0; i < TT_W; i++) mism_c = mism_c + 3'(diff[i]);
    for (int i = TT_W - 1; i >= 0; i--) if (diff[i]) fidx_c = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    pass_d  = pass_q;
    fidx_d  = fidx_q;
    mism_d  = mism_q;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        exp_d   = expected;
        tt_d    = '0;
        pass_d  = 1'b0;
        fidx_d  = '0;
        mism_d  = '0;
        idx_d   = '0;
        t_load  = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (t_zero) state_d = S_SAMPLE;
        else        t_dec   = 1'b1;
      end
      S_SAMPLE: begin
        tt_d = tt_smp;
        if (idx_q == IDX_W'(TT_W - 1)) begin
          pass_d  = (diff == '0);
          fidx_d  = fidx_c;
          mism_d  = mism_c;
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          t_load  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_FINISH: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
      mism_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
      mism_q  <= mism_d;
    end
  end

  assign vec_act  = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign gate_a   = vec_act & idx_q[0];
  assign gate_b   = vec_act & idx_q[1];
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FINISH);
  assign pass     = pass_q;
  assign tt       = tt_q;
  assign fail_idx = fidx_q;
  assign mism_cnt = mism_q;
endmodule
